// File: rtl/episode_driver_if.sv
// Step handshake between the episode driver (initiator) and the
// state/reward transition generator (responder).
interface episode_driver_if;
  logic        step_en;      // one-cycle request pulse
  logic        cur_state;    // state presented with step_en
  logic [1:0]  action;       // policy-selected action presented with step_en
  logic [15:0] random;       // uniform sample presented with step_en
  logic        step_valid;   // response valid (level)
  logic        new_state;    // next state, valid with step_valid
  logic [15:0] step_reward;  // unsigned reward, valid with step_valid

  modport master (
    output step_en, cur_state, action, random,
    input  step_valid, new_state, step_reward
  );

  modport slave (
    input  step_en, cur_state, action, random,
    output step_valid, new_state, step_reward
  );
endinterface

// File: rtl/episode_driver.sv
// Episode driver: runs one simulated POMDP episode of MAX_STEPS transitions,
// issuing one request per step to the transition generator, capturing the
// next state and reward, and accumulating a saturating reward total.
module episode_driver #(
  parameter int unsigned MAX_STEPS = 16,          // transitions per episode (1..255)
  parameter int unsigned TIMEOUT   = 8,           // WAIT cycles before error (1..255)
  parameter logic [15:0] LFSR_SEED = 16'hACE1     // nonzero LFSR value after reset
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_state,
  input  logic [1:0]       policy0,
  input  logic [1:0]       policy1,
  episode_driver_if.master step_if,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [23:0]      total_reward,
  output logic [7:0]       steps_taken
);

  localparam logic [7:0] MAX_STEPS_L = 8'(MAX_STEPS);
  localparam logic [7:0] TIMEOUT_L   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic        step_en_reg;
  logic        cur_state_reg;
  logic [1:0]  action_reg;
  logic [15:0] lfsr_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        error_reg;
  logic [23:0] total_reward_reg;
  logic [7:0]  steps_taken_reg;
  logic [7:0]  timeout_cnt_reg;
  logic        cap_state_reg;
  logic [15:0] cap_reward_reg;

  logic [15:0] lfsr_next;
  logic [24:0] sum_wide;
  logic [23:0] sum_sat;
  logic [7:0]  steps_next;
  logic [7:0]  timeout_next;
  logic [1:0]  action_from_start;
  logic [1:0]  action_from_capture;

  // Next-value helpers: LFSR step, saturating reward sum, counters and the
  // policy lookup for whichever state the next ISSUE cycle will present.
  always_comb begin
    lfsr_next           = {lfsr_reg[14:0],
                           lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    sum_wide            = {1'b0, total_reward_reg} + {9'd0, cap_reward_reg};
    sum_sat             = sum_wide[24] ? 24'hFFFFFF : sum_wide[23:0];
    steps_next          = steps_taken_reg + 8'd1;
    timeout_next        = timeout_cnt_reg + 8'd1;
    action_from_start   = start_state   ? policy1 : policy0;
    action_from_capture = cap_state_reg ? policy1 : policy0;
  end

  // Episode FSM with registered outputs. The action register is loaded on
  // entry to ISSUE with policy[cur_state], so during ISSUE it reflects the
  // registered cur_state while keeping a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      step_en_reg      <= 1'b0;
      cur_state_reg    <= 1'b0;
      action_reg       <= 2'd0;
      lfsr_reg         <= LFSR_SEED;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      total_reward_reg <= 24'd0;
      steps_taken_reg  <= 8'd0;
      timeout_cnt_reg  <= 8'd0;
      cap_state_reg    <= 1'b0;
      cap_reward_reg   <= 16'd0;
    end else begin
      step_en_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            cur_state_reg    <= start_state;
            action_reg       <= action_from_start;
            total_reward_reg <= 24'd0;
            steps_taken_reg  <= 8'd0;
            error_reg        <= 1'b0;
            busy_reg         <= 1'b1;
            step_en_reg      <= 1'b1;
            state_reg        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // step_valid is deliberately not looked at in the request cycle.
          timeout_cnt_reg <= 8'd0;
          state_reg       <= S_WAIT;
        end
        S_WAIT: begin
          if (step_if.step_valid) begin
            cap_state_reg  <= step_if.new_state;
            cap_reward_reg <= step_if.step_reward;
            lfsr_reg       <= lfsr_next;
            state_reg      <= S_UPDATE;
          end else begin
            timeout_cnt_reg <= timeout_next;
            if (timeout_next == TIMEOUT_L) begin
              error_reg <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end
        S_UPDATE: begin
          total_reward_reg <= sum_sat;
          cur_state_reg    <= cap_state_reg;
          steps_taken_reg  <= steps_next;
          if (steps_next == MAX_STEPS_L) begin
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            action_reg  <= action_from_capture;
            step_en_reg <= 1'b1;
            state_reg   <= S_ISSUE;
          end
        end
        S_DONE: begin
          // start is ignored here, including in the done-pulse cycle.
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign step_if.step_en   = step_en_reg;
  assign step_if.cur_state = cur_state_reg;
  assign step_if.action    = action_reg;
  assign step_if.random    = lfsr_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign error             = error_reg;
  assign total_reward      = total_reward_reg;
  assign steps_taken       = steps_taken_reg;

endmodule

// File: tb/tb_episode_driver.sv
// Directed, table-driven bench for episode_driver: a table of whole episodes
// with hand-computed expectations, plus hand-written sequences for start
// during busy/done, reset during WAIT and reward saturation.
module tb_episode_driver;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int R_DELAY  = 0;
  localparam int R_NEVER  = 1;
  localparam int R_ALWAYS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_state;
  logic [1:0]  policy0, policy1;
  logic        busy, done, error;
  logic [23:0] total_reward;
  logic [7:0]  steps_taken;

  logic        start_s;
  logic        state_s;
  logic [1:0]  pol_s;
  logic        busy_s, done_s, error_s;
  logic [23:0] total_s;
  logic [7:0]  steps_s;

  episode_driver_if ifm ();
  episode_driver_if ifs ();

  episode_driver #(.MAX_STEPS(4), .TIMEOUT(8), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_state(start_state),
    .policy0(policy0), .policy1(policy1), .step_if(ifm),
    .busy(busy), .done(done), .error(error),
    .total_reward(total_reward), .steps_taken(steps_taken)
  );

  episode_driver #(.MAX_STEPS(8), .TIMEOUT(8), .LFSR_SEED(SEED)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .start_state(state_s),
    .policy0(pol_s), .policy1(pol_s), .step_if(ifs),
    .busy(busy_s), .done(done_s), .error(error_s),
    .total_reward(total_s), .steps_taken(steps_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Responder for the main instance.
  int          resp_mode   = R_DELAY;
  int          resp_delay  = 0;
  logic [15:0] resp_reward = 16'd0;
  int          resp_idx    = 0;
  int          countdown   = -1;

  // Answers each request after resp_delay WAIT cycles; new_state alternates 1,0,...
  always @(posedge clk) begin : responder
    logic saw_issue, was_valid;
    saw_issue = ifm.step_en;
    was_valid = ifm.step_valid;
    #1;
    if (!rst_n) begin
      ifm.step_valid = 1'b0;
      ifm.new_state  = 1'b0;
      countdown      = -1;
    end else if (resp_mode == R_ALWAYS) begin
      ifm.step_valid = 1'b1;
      ifm.new_state  = 1'b1;
    end else begin
      if (was_valid) begin
        ifm.step_valid = 1'b0;
        resp_idx++;
      end
      if (saw_issue && resp_mode == R_DELAY) countdown = resp_delay;
      if (countdown == 0) begin
        ifm.step_valid = 1'b1;
        ifm.new_state  = (resp_idx % 2 == 0);
        countdown      = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
    end
    ifm.step_reward = resp_reward;
  end

  // Responder for the saturation instance: always valid, maximum reward.
  always @(posedge clk) begin : responder_sat
    #1;
    ifs.step_valid  = rst_n;
    ifs.new_state   = 1'b0;
    ifs.step_reward = 16'hFFFF;
  end

  // Monitor: record request pulses and done pulses of the main instance.
  int         en_cyc[$];
  logic [1:0] en_act[$];
  logic [15:0] en_rnd[$];
  int         done_cyc[$];

  always @(negedge clk) begin
    if (ifm.step_en) begin
      en_cyc.push_back(cyc);
      en_act.push_back(ifm.action);
      en_rnd.push_back(ifm.random);
    end
    if (done) done_cyc.push_back(cyc);
  end

  typedef struct {
    logic        ss;
    logic [1:0]  p0, p1;
    int          mode;
    int          delay;
    logic [15:0] rew;
    int          n_en;
    logic [3:0][1:0] act;
    logic [23:0] tot;
    logic [7:0]  steps;
    logic        err;
    int          len;
  } vec_t;

  function automatic vec_t mk(input logic ss, input logic [1:0] p0, input logic [1:0] p1,
                              input int mode, input int delay, input logic [15:0] rew,
                              input int n_en, input logic [1:0] a0, input logic [1:0] a1,
                              input logic [1:0] a2, input logic [1:0] a3,
                              input logic [23:0] tot, input logic [7:0] steps,
                              input logic err, input int len);
    vec_t v;
    v.ss = ss; v.p0 = p0; v.p1 = p1; v.mode = mode; v.delay = delay; v.rew = rew;
    v.n_en = n_en; v.act[0] = a0; v.act[1] = a1; v.act[2] = a2; v.act[3] = a3;
    v.tot = tot; v.steps = steps; v.err = err; v.len = len;
    return v;
  endfunction

  logic [15:0] exp_lfsr = SEED;
  int          issue_cyc;

  task automatic clear_mon();
    en_cyc.delete(); en_act.delete(); en_rnd.delete(); done_cyc.delete();
  endtask

  task automatic wait_done(input string nm);
    int budget;
    budget = 0;
    while (done_cyc.size() == 0 && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    chk({nm, ".done_seen"}, done_cyc.size() > 0, 1);
  endtask

  // One episode from the table: start, wait for done, compare everything.
  task automatic run_vec(input vec_t v, input int id);
    logic [15:0] r;
    string       pfx;
    int          lim;
    pfx = $sformatf("v%0d", id);
    resp_mode = v.mode; resp_delay = v.delay; resp_reward = v.rew;
    start_state = v.ss; policy0 = v.p0; policy1 = v.p1;
    @(negedge clk); @(negedge clk);
    resp_idx = 0;
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue_cyc = cyc;
    wait_done(pfx);
    repeat (3) @(negedge clk);
    #1;
    chk({pfx, ".n_en"}, en_cyc.size(), v.n_en);
    lim = (en_cyc.size() < v.n_en) ? en_cyc.size() : v.n_en;
    r = exp_lfsr;
    for (int k = 0; k < lim; k++) begin
      chk($sformatf("%s.act%0d", pfx, k), en_act[k], v.act[k]);
      chk($sformatf("%s.rnd%0d", pfx, k), en_rnd[k], r);
      if (k > 0)
        chk($sformatf("%s.gap%0d", pfx, k), en_cyc[k] - en_cyc[k-1],
            (v.mode == R_ALWAYS) ? 3 : 3 + v.delay);
      r = lfsr_step(r);
    end
    chk({pfx, ".total"}, total_reward, v.tot);
    chk({pfx, ".steps"}, steps_taken, v.steps);
    chk({pfx, ".error"}, error, v.err);
    chk({pfx, ".busy_after"}, busy, 0);
    chk({pfx, ".n_done"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk({pfx, ".len"}, done_cyc[0] - issue_cyc + 1, v.len);
    for (int k = 0; k < v.steps; k++) exp_lfsr = lfsr_step(exp_lfsr);
  endtask

  task automatic wait_steps_s(input logic [7:0] n);
    int budget;
    budget = 0;
    while (steps_s != n && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    chk($sformatf("sat.reach_steps%0d", n), steps_s, n);
  endtask

  vec_t vecs[7];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int budget;
    vecs[0] = mk(1'b0, 2'd2, 2'd1, R_DELAY,  0, 16'd100,  4, 2'd2, 2'd1, 2'd2, 2'd1, 24'd400,     8'd4, 1'b0, 13);
    vecs[1] = mk(1'b1, 2'd3, 2'd0, R_DELAY,  2, 16'hFFFF, 4, 2'd0, 2'd0, 2'd3, 2'd0, 24'h03FFFC,  8'd4, 1'b0, 21);
    vecs[2] = mk(1'b0, 2'd1, 2'd2, R_NEVER,  0, 16'd50,   1, 2'd1, 2'd0, 2'd0, 2'd0, 24'd0,       8'd0, 1'b1, 10);
    vecs[3] = mk(1'b0, 2'd0, 2'd3, R_DELAY,  0, 16'd7,    4, 2'd0, 2'd3, 2'd0, 2'd3, 24'd28,      8'd4, 1'b0, 13);
    vecs[4] = mk(1'b0, 2'd1, 2'd2, R_DELAY,  7, 16'd1,    4, 2'd1, 2'd2, 2'd1, 2'd2, 24'd4,       8'd4, 1'b0, 41);
    vecs[5] = mk(1'b1, 2'd1, 2'd2, R_DELAY,  8, 16'd9,    1, 2'd2, 2'd0, 2'd0, 2'd0, 24'd0,       8'd0, 1'b1, 10);
    vecs[6] = mk(1'b0, 2'd2, 2'd3, R_ALWAYS, 0, 16'd5,    4, 2'd2, 2'd3, 2'd3, 2'd3, 24'd20,      8'd4, 1'b0, 13);

    rst_n = 1'b0; start = 1'b0; start_state = 1'b0; policy0 = 2'd0; policy1 = 2'd0;
    start_s = 1'b0; state_s = 1'b0; pol_s = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Reset values
    chk("rst.step_en", ifm.step_en, 0);
    chk("rst.cur_state", ifm.cur_state, 0);
    chk("rst.action", ifm.action, 0);
    chk("rst.random", ifm.random, SEED);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    chk("rst.total", total_reward, 0);
    chk("rst.steps", steps_taken, 0);

    // Table of whole episodes; vector 0 also checks random = seed, then its successor.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    chk("seq.first_random_after_lfsr_step", lfsr_step(SEED), 16'h59C3);

    // start held high through the whole episode and the done-pulse cycle
    resp_mode = R_DELAY; resp_delay = 0; resp_reward = 16'd3;
    start_state = 1'b0; policy0 = 2'd1; policy1 = 2'd1;
    @(negedge clk); @(negedge clk);
    resp_idx = 0;
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    issue_cyc = cyc;
    wait_done("hold");
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("hold.n_en", en_cyc.size(), 4);
    chk("hold.n_done", done_cyc.size(), 1);
    chk("hold.total", total_reward, 24'd12);
    chk("hold.steps", steps_taken, 4);
    chk("hold.busy_after", busy, 0);
    for (int k = 0; k < 4; k++) exp_lfsr = lfsr_step(exp_lfsr);

    // reset asserted in the first WAIT cycle of step 2
    resp_mode = R_DELAY; resp_delay = 2; resp_reward = 16'd9;
    @(negedge clk); @(negedge clk);
    resp_idx = 0;
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (en_cyc.size() < 2 && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    chk("rstmid.reached_step2", en_cyc.size(), 2);
    @(negedge clk); #1;
    chk("rstmid.pre_total", total_reward, 24'd9);
    chk("rstmid.pre_steps", steps_taken, 1);
    chk("rstmid.pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.step_en", ifm.step_en, 0);
    chk("rstmid.cur_state", ifm.cur_state, 0);
    chk("rstmid.action", ifm.action, 0);
    chk("rstmid.random", ifm.random, SEED);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.error", error, 0);
    chk("rstmid.total", total_reward, 0);
    chk("rstmid.steps", steps_taken, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid.n_done", done_cyc.size(), 0);
    chk("rstmid.busy_after", busy, 0);
    exp_lfsr = SEED;
    run_vec(vecs[0], 7);

    // Saturation: preload the accumulator near full scale after start clears it.
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    force dut_sat.total_reward_reg = 24'hFD0000;
    #1;
    release dut_sat.total_reward_reg;
    wait_steps_s(8'd3);
    chk("sat.total3", total_s, 24'hFFFFFD);
    wait_steps_s(8'd4);
    chk("sat.total4", total_s, 24'hFFFFFF);
    wait_steps_s(8'd6);
    chk("sat.total6", total_s, 24'hFFFFFF);
    budget = 0;
    while (!done_s && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    chk("sat.done_seen", done_s, 1);
    chk("sat.total_final", total_s, 24'hFFFFFF);
    chk("sat.steps_final", steps_s, 8);
    chk("sat.error", error_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
